// File: rtl/multiport_register_file.sv
// multiport_register_file: architectural register file with configurable
// read/write port counts, write-to-read bypass, a per-register busy
// scoreboard and a handshaked dump engine that streams every register.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   rd_addr / rd_data     NUM_READ combinational read ports (x0 reads 0)
//   rd_busy               registered busy bit of each addressed register
//   wr_en/addr/data       NUM_WRITE write ports, higher index wins
//   busy_set/busy_addr    mark a register as having an outstanding producer
//   dump_start            start streaming all registers
//   dump_valid/ready      beat handshake
//   dump_index/data       current beat (held stable while stalled)
//   dump_done             one-cycle pulse after the last beat is accepted
module multiport_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_READ*$clog2(REG_COUNT)-1:0]    rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_READ-1:0]                      rd_busy,
    input  logic [NUM_WRITE-1:0]                     wr_en,
    input  logic [NUM_WRITE*$clog2(REG_COUNT)-1:0]   wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]          wr_data,
    input  logic                                     busy_set,
    input  logic [$clog2(REG_COUNT)-1:0]             busy_addr,
    input  logic                                     dump_start,
    output logic                                     dump_valid,
    input  logic                                     dump_ready,
    output logic [$clog2(REG_COUNT)-1:0]             dump_index,
    output logic [DATA_WIDTH-1:0]                    dump_data,
    output logic                                     dump_done
);

    localparam int unsigned AW = $clog2(REG_COUNT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;

    logic [1:0]            state_q, state_d;
    logic                  dump_valid_q, dump_valid_d;
    logic [AW-1:0]         dump_index_q, dump_index_d;
    logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
    logic                  dump_done_q, dump_done_d;

    // Array and scoreboard update; a busy_set overrides a same-cycle clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (busy_set && (busy_addr != '0)) begin
            busy_d[busy_addr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // Read ports; later write ports override earlier ones in the bypass scan.
    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            data = regs_q[addr];
            if (BYPASS != 0) begin
                for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                        data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (addr == '0) begin
                data = '0;
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_busy[p] = busy_q[addr] & (addr != '0);
    end

    // Dump engine; beats sample the pre-edge array so same-edge writes are not seen.
    always_comb begin
        state_d      = state_q;
        dump_valid_d = dump_valid_q;
        dump_index_d = dump_index_q;
        dump_data_d  = dump_data_q;
        dump_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    dump_index_d = '0;
                    dump_data_d  = '0;
                    dump_valid_d = 1'b1;
                    state_d      = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (dump_valid_q && dump_ready) begin
                    if (dump_index_q == AW'(REG_COUNT - 1)) begin
                        dump_valid_d = 1'b0;
                        dump_done_d  = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        dump_index_d = dump_index_q + AW'(1);
                        dump_data_d  = regs_q[dump_index_q + AW'(1)];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                dump_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            state_q      <= ST_IDLE;
            dump_valid_q <= 1'b0;
            dump_index_q <= '0;
            dump_data_q  <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            state_q      <= state_d;
            dump_valid_q <= dump_valid_d;
            dump_index_q <= dump_index_d;
            dump_data_q  <= dump_data_d;
            dump_done_q  <= dump_done_d;
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_index = dump_index_q;
    assign dump_data  = dump_data_q;
    assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: one bypassing and one non-bypassing
// instance share all inputs; vectors cover reads/writes/scoreboard, then
// hand-written sequences cover the dump engine and reset mid-dump.
module tb_multiport_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, nb_rd_data;
    logic [1:0]  rd_busy, nb_rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        busy_set;
    logic [4:0]  busy_addr;
    logic        dump_start, dump_ready;
    logic        dump_valid, nb_dump_valid;
    logic [4:0]  dump_index, nb_dump_index;
    logic [31:0] dump_data, nb_dump_data;
    logic        dump_done, nb_dump_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiport_register_file #(
        .DATA_WIDTH(32), .REG_COUNT(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1)
    ) u_dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_index(dump_index), .dump_data(dump_data), .dump_done(dump_done)
    );

    multiport_register_file #(
        .DATA_WIDTH(32), .REG_COUNT(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(0)
    ) u_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .dump_start(dump_start), .dump_valid(nb_dump_valid), .dump_ready(dump_ready),
        .dump_index(nb_dump_index), .dump_data(nb_dump_data), .dump_done(nb_dump_done)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        bs;
        logic [4:0]  ba;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
        logic [31:0] en0;
        logic [31:0] en1;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    localparam int NV = 22;
    vec_t  vecs [NV];
    vec_t  vq [$];
    beat_t bq [$];

    function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                                logic [4:0] wa1, logic [31:0] wd1, logic bs, logic [4:0] ba,
                                logic [4:0] ra0, logic [4:0] ra1, logic [31:0] ed0,
                                logic [31:0] ed1, logic eb0, logic eb1,
                                logic [31:0] en0, logic [31:0] en1);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.bs = bs; v.ba = ba; v.ra0 = ra0; v.ra1 = ra1;
        v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1; v.en0 = en0; v.en1 = en1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        busy_set = 1'b0; busy_addr = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
    endtask

    initial begin
        vec_t  e;
        beat_t b;
        int    beats, dones, post, cyc;
        bit    reached;

        //          we     wa0 wd0            wa1 wd1    bs ba ra0 ra1 ed0            ed1            eb0 eb1 en0            en1
        vecs[0]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 0, 5, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
        vecs[1]  = mk(2'b01, 5, 32'hDEADBEEF,  0, 32'h0,  0, 0, 5, 5, 32'hDEADBEEF,  32'hDEADBEEF,  0, 0, 32'h0,         32'h0);
        vecs[2]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 5, 5, 32'hDEADBEEF,  32'hDEADBEEF,  0, 0, 32'hDEADBEEF,  32'hDEADBEEF);
        vecs[3]  = mk(2'b01, 0, 32'h1234,      0, 32'h0,  0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
        vecs[4]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 0, 5, 32'h0,         32'hDEADBEEF,  0, 0, 32'h0,         32'hDEADBEEF);
        vecs[5]  = mk(2'b01, 7, 32'hA5A5A5A5,  0, 32'h0,  0, 0, 7, 7, 32'hA5A5A5A5,  32'hA5A5A5A5,  0, 0, 32'h0,         32'h0);
        vecs[6]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 7, 7, 32'hA5A5A5A5,  32'hA5A5A5A5,  0, 0, 32'hA5A5A5A5,  32'hA5A5A5A5);
        vecs[7]  = mk(2'b11, 3, 32'h11,        3, 32'h22, 0, 0, 3, 3, 32'h22,        32'h22,        0, 0, 32'h0,         32'h0);
        vecs[8]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 3, 3, 32'h22,        32'h22,        0, 0, 32'h22,        32'h22);
        vecs[9]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  1, 9, 9, 9, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
        vecs[10] = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 9, 9, 32'h0,         32'h0,         1, 1, 32'h0,         32'h0);
        vecs[11] = mk(2'b01, 9, 32'h99,        0, 32'h0,  0, 0, 9, 9, 32'h99,        32'h99,        1, 1, 32'h0,         32'h0);
        vecs[12] = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 9, 9, 32'h99,        32'h99,        0, 0, 32'h99,        32'h99);
        vecs[13] = mk(2'b10, 0, 32'h0,         9, 32'hAA, 1, 9, 9, 9, 32'hAA,        32'hAA,        0, 0, 32'h99,        32'h99);
        vecs[14] = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 9, 9, 32'hAA,        32'hAA,        1, 1, 32'hAA,        32'hAA);
        vecs[15] = mk(2'b00, 0, 32'h0,         0, 32'h0,  1, 0, 0, 9, 32'h0,         32'hAA,        0, 1, 32'h0,         32'hAA);
        vecs[16] = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 0, 9, 32'h0,         32'hAA,        0, 1, 32'h0,         32'hAA);
        vecs[17] = mk(2'b11, 4, 32'h44,        6, 32'h66, 0, 0, 4, 6, 32'h44,        32'h66,        0, 0, 32'h0,         32'h0);
        vecs[18] = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 4, 6, 32'h44,        32'h66,        0, 0, 32'h44,        32'h66);
        vecs[19] = mk(2'b11, 8, 32'h80,        0, 32'hFF, 0, 0, 0, 8, 32'h0,         32'h80,        0, 0, 32'h0,         32'h0);
        vecs[20] = mk(2'b00, 0, 32'h0,         0, 32'h0,  0, 0, 0, 8, 32'h0,         32'h80,        0, 0, 32'h0,         32'h80);
        vecs[21] = mk(2'b11, 3, 32'h33,        4, 32'h55, 0, 0, 3, 4, 32'h33,        32'h55,        0, 0, 32'h22,        32'h44);

        idle_inputs();
        rd_addr = '0;
        reset = 1'b1;
        #12;
        chk("rst_dump_valid", 32'(dump_valid), 32'h0);
        chk("rst_dump_done",  32'(dump_done),  32'h0);
        chk("rst_dump_index", 32'(dump_index), 32'h0);
        chk("rst_dump_data",  dump_data,       32'h0);
        chk("rst_rd_data",    rd_data[31:0],   32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven read/write/scoreboard vectors.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            wr_en = vecs[i].we;
            wr_addr = {vecs[i].wa1, vecs[i].wa0};
            wr_data = {vecs[i].wd1, vecs[i].wd0};
            busy_set = vecs[i].bs;
            busy_addr = vecs[i].ba;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            vq.push_back(vecs[i]);
            @(negedge clk);
            e = vq.pop_front();
            chk($sformatf("v%0d_rd0", i), rd_data[31:0], e.ed0);
            chk($sformatf("v%0d_rd1", i), rd_data[63:32], e.ed1);
            chk($sformatf("v%0d_busy0", i), 32'(rd_busy[0]), 32'(e.eb0));
            chk($sformatf("v%0d_busy1", i), 32'(rd_busy[1]), 32'(e.eb1));
            chk($sformatf("v%0d_nb_rd0", i), nb_rd_data[31:0], e.en0);
            chk($sformatf("v%0d_nb_rd1", i), nb_rd_data[63:32], e.en1);
            chk($sformatf("v%0d_nb_busy", i), 32'(nb_rd_busy), {30'b0, e.eb1, e.eb0});
        end
        @(posedge clk); #1;
        idle_inputs();

        // Preload xi = i*0x10 two registers per cycle.
        for (int i = 1; i < 32; i += 2) begin
            wr_en   = (i + 1 < 32) ? 2'b11 : 2'b01;
            wr_addr = {5'(i + 1), 5'(i)};
            wr_data = {32'((i + 1) * 16), 32'(i * 16)};
            @(posedge clk); #1;
        end
        idle_inputs();

        // Dump with ready toggling; a write to the stalled index must not disturb the beat.
        dump_start = 1'b1;
        for (int k = 0; k < 32; k++) begin
            b.idx = 5'(k); b.data = 32'(k * 16);
            bq.push_back(b);
        end
        @(posedge clk); #1;
        dump_start = 1'b0;
        beats = 0; dones = 0; post = 0;
        for (cyc = 0; cyc < 200; cyc++) begin
            dump_ready = cyc[0];
            dump_start = (cyc == 20);
            if (dump_valid && dump_index == 5'd5 && !dump_ready) begin
                wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h0BAD};
            end else begin
                wr_en = 2'b00;
            end
            @(negedge clk);
            if (dump_done) begin
                dones++;
                chk("done_valid_low", 32'(dump_valid), 32'h0);
                chk("done_after_all_beats", 32'(beats), 32'd32);
            end
            if (nb_dump_done) chk("nb_done_with_dut", 32'(dump_done), 32'h1);
            if (dump_valid) begin
                if (bq.size() == 0) begin
                    chk("beat_overflow", 32'(bq.size()), 32'h1);
                end else begin
                    b = bq[0];
                    chk($sformatf("beat%0d_index", b.idx), 32'(dump_index), 32'(b.idx));
                    chk($sformatf("beat%0d_data", b.idx), dump_data, b.data);
                    chk($sformatf("nb_beat%0d_index", b.idx), 32'(nb_dump_index), 32'(b.idx));
                    chk($sformatf("nb_beat%0d_data", b.idx), nb_dump_data, b.data);
                    if (dump_ready) begin
                        void'(bq.pop_front());
                        beats++;
                    end
                end
            end
            if (dones > 0) post++;
            if (post >= 4) break;
            @(posedge clk); #1;
        end
        chk("dump_beats", 32'(beats), 32'd32);
        chk("dump_done_pulses", 32'(dones), 32'd1);
        chk("dump_queue_empty", 32'(bq.size()), 32'd0);
        chk("nb_dump_valid_idle", 32'(nb_dump_valid), 32'h0);

        // Reset at beat 10 of a dump.
        @(posedge clk); #1;
        idle_inputs();
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        dump_ready = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dump_valid && dump_index == 5'd10) begin
                reached = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_beat10", 32'(reached), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(dump_valid), 32'h0);
        chk("rst_mid_index", 32'(dump_index), 32'h0);
        chk("rst_mid_data",  dump_data,       32'h0);
        chk("rst_mid_nb_valid", 32'(nb_dump_valid), 32'h0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) reset = 1'b0;
            if (dump_done || dump_valid) dones++;
        end
        chk("rst_mid_no_done", 32'(dones), 32'h0);
        dump_ready = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            rd_addr = {5'(2 * i + 1), 5'(2 * i)};
            @(negedge clk);
            chk($sformatf("post_rst_x%0d", 2 * i), rd_data[31:0], 32'h0);
            chk($sformatf("post_rst_x%0d", 2 * i + 1), rd_data[63:32], 32'h0);
            chk($sformatf("post_rst_busy_pair%0d", i), 32'(rd_busy), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Next-generation architectural register file for the RISC-V CPU, built for pipelined cores.
- Configurable width, depth, number of read ports and number of write ports.
- Adds write-to-read bypass, a per-register busy scoreboard for hazard detection, and a handshaked debug dump engine that streams register contents for bench/debug visibility.
- x0 is hardwired to zero and is never busy.

Parameters:
- DATA_WIDTH, 32, register width in bits
- REG_COUNT, 32, number of registers; power of two, >= 2; AW = $clog2(REG_COUNT)
- NUM_READ, 2, read ports, 1..4
- NUM_WRITE, 1, write ports, 1..2; on a same-register collision the higher index wins
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return the pre-write value

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- rd_addr  in  NUM_READ*AW  read addresses; port p occupies slice [p*AW +: AW]
- rd_data  out  NUM_READ*DATA_WIDTH  combinational read data per port
- rd_busy  out  NUM_READ  scoreboard busy bit of each addressed register
- wr_en  in  NUM_WRITE  write enables
- wr_addr  in  NUM_WRITE*AW  write addresses
- wr_data  in  NUM_WRITE*DATA_WIDTH  write data
- busy_set  in  1  mark register busy_addr as having an outstanding producer
- busy_addr  in  AW  register to mark busy
- dump_start  in  1  request a full register dump
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts the dump beat
- dump_index  out  AW  register index of the current beat
- dump_data  out  DATA_WIDTH  register value of the current beat
- dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (asynchronous): all registers = 0; all busy bits = 0; dump FSM = IDLE; dump_valid = 0; dump_done = 0; dump_index = 0; dump_data = 0.
- Reads, combinational:
  - rd_data = 0 and rd_busy = 0 when the address is 0.
  - With BYPASS = 1, a read whose address matches an enabled nonzero write this cycle returns that write's data (highest-index matching port).
  - With BYPASS = 0, reads return the array value.
  - rd_busy always reflects the registered busy bit; it is not bypassed.
- Writes:
  - On each rising edge, every enabled write with a nonzero address updates its register.
  - Writes to x0 are discarded.
  - Two ports writing the same register: the higher port index wins.
- Scoreboard:
  - An enabled nonzero write clears that register's busy bit.
  - busy_set with a nonzero address sets the busy bit; busy_set to x0 is ignored.
  - busy_set and a write to the same register in the same cycle: set wins, so the bit stays 1 (a new producer has been issued).
  - Busy bits are visible on rd_busy the cycle after the edge that changes them.
- Dump FSM, states IDLE, STREAM, DONE:
  - IDLE: dump_start loads dump_index = 0 and dump_data = the register 0 value (0), sets dump_valid = 1, and moves to STREAM.
  - STREAM: a beat transfers on an edge where dump_valid and dump_ready are both high.
    - Not last beat: dump_index increments and dump_data captures the next register's pre-edge array value; same-edge writes are not reflected.
    - Last beat (index REG_COUNT-1 accepted): dump_valid = 0, move to DONE.
  - DONE: dump_done = 1 for exactly one cycle, then IDLE.
  - While dump_valid = 1 and dump_ready = 0, dump_index and dump_data are held stable, even if the register is written meanwhile.
  - dump_start outside IDLE is ignored.
  - Normal reads, writes and scoreboard updates operate unaffected during a dump.
- Reset asserted mid-dump aborts the dump immediately. Outputs go to their reset values and no dump_done pulse is issued.
- Widths: addresses are exactly AW bits, so every address is in range; no wrap logic is required.

Test Plan:
- Reset, then write x5 = 0xDEADBEEF on port 0; read x5 on both ports the next cycle -> 0xDEADBEEF. Write x0 = 0x1234 -> reads of x0 return 0.
- BYPASS = 1: in the same cycle, write x7 = 0xA5A5A5A5 and read x7 -> rd_data = 0xA5A5A5A5 combinationally. BYPASS = 0: same stimulus -> old value 0 until the next cycle.
- NUM_WRITE = 2: both ports write x3, port 0 = 0x11 and port 1 = 0x22 -> x3 = 0x22.
- busy_set x9 -> rd_busy = 1 next cycle. Write x9 alone -> busy 0. Write x9 together with busy_set x9 -> busy stays 1. busy_set x0 -> rd_busy for x0 stays 0.
- Preload xi = i*0x10. Pulse dump_start with dump_ready toggling 1/0 -> REG_COUNT beats, index 0..31 with data i*0x10, data held during stalls, then a single dump_done pulse. A write to the currently stalled index leaves dump_data unchanged.
- Assert reset at beat 10 of a dump -> dump_valid = 0 immediately, no dump_done, all registers read 0 afterwards.
